// File: rtl/program_sequencer_if.sv
// program_sequencer_if: decoder-side control inputs and address/stack status
// outputs of the program sequencer.
interface program_sequencer_if #(
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 4
);
    logic                         sync_reset;
    logic                         jump;
    logic                         conditional_jump;
    logic                         call;
    logic                         ret;
    logic [3:0]                   jmp_addr;
    logic                         r_eq_0;
    logic [PC_WIDTH-1:0]          pm_addr;
    logic [PC_WIDTH-1:0]          pc;
    logic [$clog2(STACK_DEPTH):0] sp;
    logic                         stack_err;

    modport master (
        output sync_reset, jump, conditional_jump, call, ret, jmp_addr, r_eq_0,
        input  pm_addr, pc, sp, stack_err
    );

    modport slave (
        input  sync_reset, jump, conditional_jump, call, ret, jmp_addr, r_eq_0,
        output pm_addr, pc, sp, stack_err
    );
endinterface

// File: rtl/program_sequencer.sv
// program_sequencer: selects the next program-memory address (increment, jump,
// conditional jump, call, return) and keeps a small return-address stack.
module program_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 4
) (
    input logic               clk,
    input logic               reset_n,
    program_sequencer_if.slave bus
);
    localparam int SPW = $clog2(STACK_DEPTH) + 1;
    localparam logic [SPW-1:0] FULL = SPW'(STACK_DEPTH);

    logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc, target, top;
    logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [SPW-1:0]      sp_q, sp_d;
    logic [SPW-2:0]      wr_idx, rd_idx;
    logic                err_q, err_d, taken, push, pop, under, over;

    always_comb begin
        pc_inc = pc_q + PC_WIDTH'(1);
        target = PC_WIDTH'(bus.jmp_addr) << (PC_WIDTH - 4);
        wr_idx = sp_q[SPW-2:0];
        rd_idx = wr_idx - (SPW-1)'(1);
        top    = stack_q[rd_idx];
        // over/under only count when that control actually wins the priority
        under  = bus.ret && sp_q == '0;
        over   = !bus.ret && bus.call && sp_q == FULL;
        pop    = !bus.sync_reset && bus.ret && !under;
        push   = !bus.sync_reset && !bus.ret && bus.call && !over;
        taken  = bus.call || bus.jump || (bus.conditional_jump && !bus.r_eq_0);
        pc_d   = bus.sync_reset ? '0 : bus.ret ? (under ? pc_inc : top) : taken ? target : pc_inc;
        sp_d   = bus.sync_reset ? '0 : pop ? sp_q - SPW'(1) : push ? sp_q + SPW'(1) : sp_q;
        err_d  = !bus.sync_reset && (err_q || under || over);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= '0;
            sp_q  <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
            if (push) stack_q[wr_idx] <= pc_inc;
        end
    end

    assign bus.pm_addr   = reset_n ? pc_d : '0;
    assign bus.pc        = pc_q;
    assign bus.sp        = sp_q;
    assign bus.stack_err = err_q;
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: scoreboard bench; a queue-based stack model predicts each
// cycle's outputs, a negedge monitor pops and compares them.
module tb_program_sequencer;
    logic clk = 1'b0;
    logic reset_n;

    program_sequencer_if #(.PC_WIDTH(8), .STACK_DEPTH(4)) bus ();
    program_sequencer #(.PC_WIDTH(8), .STACK_DEPTH(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pm;
        logic [7:0] pc;
        int         sp;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] m_stack[$];
    logic [7:0] m_pc;
    logic       m_err;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("pm_addr", 32'(bus.pm_addr), 32'(mon_e.pm));
            chk("pc", 32'(bus.pc), 32'(mon_e.pc));
            chk("sp", 32'(bus.sp), 32'(mon_e.sp));
            chk("stack_err", 32'(bus.stack_err), 32'(mon_e.err));
        end
    end

    // Called at posedge+1: applies controls, records the prediction, then advances one cycle.
    task automatic drive(input bit s, input bit j, input bit cj, input bit c, input bit r,
                         input bit [3:0] a, input bit z);
        exp_t       e;
        logic [7:0] inc, tgt, pm;
        bus.sync_reset = s; bus.jump = j; bus.conditional_jump = cj;
        bus.call = c; bus.ret = r; bus.jmp_addr = a; bus.r_eq_0 = z;
        e.pc  = m_pc;
        e.sp  = m_stack.size();
        e.err = m_err;
        inc   = m_pc + 8'd1;
        tgt   = {a, 4'h0};
        if (s) begin
            pm = 8'h00; m_stack.delete(); m_err = 1'b0;
        end else if (r) begin
            if (m_stack.size() > 0) pm = m_stack.pop_back();
            else begin pm = inc; m_err = 1'b1; end
        end else if (c) begin
            pm = tgt;
            if (m_stack.size() < 4) m_stack.push_back(inc);
            else m_err = 1'b1;
        end else if (j || (cj && !z)) pm = tgt;
        else pm = inc;
        e.pm = pm;
        m_pc = pm;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 4'h0, 0);
    endtask

    task automatic goto(input logic [7:0] v);
        drive(0, 1, 0, 0, 0, v[7:4], 0);
        while (m_pc != v) idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        bus.sync_reset = 0; bus.jump = 0; bus.conditional_jump = 0;
        bus.call = 0; bus.ret = 0; bus.jmp_addr = 4'h0; bus.r_eq_0 = 0;
        m_pc = 8'h00; m_err = 1'b0; m_stack.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", 32'(bus.pc), 32'h0);
        chk("reset_pm_addr", 32'(bus.pm_addr), 32'h0);
        chk("reset_sp", 32'(bus.sp), 32'h0);
        chk("reset_err", 32'(bus.stack_err), 32'h0);
        reset_n = 1'b1;
        repeat (3) idle();
        goto(8'h05);
        drive(0, 1, 0, 0, 0, 4'hA, 0);
        drive(0, 0, 1, 0, 0, 4'h3, 1);
        drive(0, 0, 1, 0, 0, 4'h3, 0);
        goto(8'h12);
        drive(0, 0, 0, 1, 0, 4'h4, 0);
        repeat (3) idle();
        drive(0, 0, 0, 0, 1, 4'h0, 0);
        idle();
        goto(8'h00);
        for (int i = 1; i <= 5; i++) drive(0, 0, 0, 1, 0, 4'(i), 0);
        repeat (5) drive(0, 0, 0, 0, 1, 4'h0, 0);
        drive(1, 0, 0, 0, 0, 4'h0, 0);
        idle();
        goto(8'h76);
        drive(0, 0, 0, 1, 0, 4'h0, 0);
        drive(0, 1, 0, 1, 1, 4'h9, 0);
        idle();
        goto(8'hFF);
        idle();
        goto(8'hFF);
        drive(0, 0, 0, 1, 0, 4'h2, 0);
        drive(0, 0, 0, 0, 1, 4'h0, 0);
        idle();
        for (int i = 0; i < 400; i++)
            drive($urandom_range(31) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
                  $urandom_range(3) == 0, $urandom_range(3) == 0, 4'($urandom_range(15)),
                  $urandom_range(1) == 1);
        drive(0, 0, 0, 1, 0, 4'h7, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_pc", 32'(bus.pc), 32'h0);
        chk("async_sp", 32'(bus.sp), 32'h0);
        chk("async_err", 32'(bus.stack_err), 32'h0);
        chk("async_pm_addr", 32'(bus.pm_addr), 32'h0);
        m_pc = 8'h00; m_err = 1'b0; m_stack.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
